instr_fetch: RTL and testbench

//  Fetch stage directly downstream of the PC register. Uses the current PC to issue word reads
//  to instruction memory over a valid/ready request channel and queues each {pc, instr} pair.

---
 rtl/instr_fetch.sv | 153 +++++++++++++++
 tb/tb_instr_fetch.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: issues imem word reads at pc, queues {pc,instr}, drives next_pc.
// Optional misaligned-fetch trap: define FETCH_MISALIGN_TRAP_EN.
module instr_fetch #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                FIFO_DEPTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] next_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic              fetch_misalign,
`endif
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [DATA_W-1:0] if_instr,
   input  logic              if_ready
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   localparam logic [1:0] RUN   = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_n;
   logic [ADDR_W-1:0] req_pc;
   logic [CW-1:0]     count;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [ADDR_W-1:0] pc_q    [FIFO_DEPTH];
   logic [DATA_W-1:0] instr_q [FIFO_DEPTH];

   logic misalign_blk;
   logic accept;
   logic push;
   logic pop;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic mis_q;

   assign misalign_blk   = (pc[1:0] != 2'b00);
   assign fetch_misalign = mis_q;
   assign imem_req_addr  = pc;

   // Sticky trap flag, raised on a misaligned pc in RUN, cleared by redirect.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mis_q <= 1'b0;
      end else if (redirect_valid) begin
         mis_q <= 1'b0;
      end else if ((state == RUN) && misalign_blk) begin
         mis_q <= 1'b1;
      end
   end
`else
   assign misalign_blk  = 1'b0;
   assign imem_req_addr = {pc[ADDR_W-1:2], 2'b00};
`endif

   assign imem_req_valid = reset
                         & (state == RUN)
                         & (count < DEPTH_C)
                         & ~redirect_valid
                         & ~misalign_blk;

   assign accept = imem_req_valid & imem_req_ready;
   assign push   = (state == WAIT) & imem_rsp_valid & ~redirect_valid;
   assign if_valid = (count != '0);
   assign pop    = if_valid & if_ready & ~redirect_valid;

   assign if_pc    = pc_q[rd_ptr];
   assign if_instr = instr_q[rd_ptr];

   // Next PC select: reset value, redirect target, sequential, or hold.
   always_comb begin
      next_pc = pc;
      unique case (1'b1)
         !reset:         next_pc = RESET_PC;
         redirect_valid: next_pc = redirect_pc;
         accept:         next_pc = pc + ADDR_W'(4);
         default:        next_pc = pc;
      endcase
   end

   // Request/response tracker; a redirect turns an outstanding read stale.
   always_comb begin
      state_n = state;
      unique case (state)
         RUN: begin
            if (accept) state_n = WAIT;
         end
         WAIT: begin
            if (imem_rsp_valid)      state_n = RUN;
            else if (redirect_valid) state_n = DRAIN;
         end
         DRAIN: begin
            if (imem_rsp_valid) state_n = RUN;
         end
         default: state_n = RUN;
      endcase
   end

   // State and captured request pc.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= RUN;
         req_pc <= '0;
      end else begin
         state <= state_n;
         if (accept) req_pc <= pc;
      end
   end

   // Fetch queue: flush on redirect, otherwise push/pop with preserved order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
      end else if (redirect_valid) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            pc_q[wr_ptr]    <= req_pc;
            instr_q[wr_ptr] <= imem_rsp_data;
            wr_ptr          <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (!push && pop) count <= count - CW'(1);
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a PC register and 1-cycle memory model.
// Define FETCH_MISALIGN_TRAP_EN to exercise the trap build.
module tb_instr_fetch;

   localparam logic [31:0] K = 32'h1300_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b1;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fetch_misalign;
`endif

   logic        pend;
   logic        hold = 1'b0;
   logic [31:0] paddr;

   int checks = 0;
   int fails  = 0;

   instr_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .pc             (pc),
      .next_pc        (next_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
`ifdef FETCH_MISALIGN_TRAP_EN
      .fetch_misalign (fetch_misalign),
`endif
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_ready       (if_ready)
   );

   always #5 clk = ~clk;

   // PC register
   always @(posedge clk or negedge reset) begin
      if (!reset) pc <= 32'h0;
      else        pc <= next_pc;
   end

   // Memory: answers one cycle after accept unless held
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend  <= 1'b0;
         paddr <= '0;
      end else if (imem_req_valid && imem_req_ready) begin
         pend  <= 1'b1;
         paddr <= imem_req_addr;
      end else if (imem_rsp_valid) begin
         pend <= 1'b0;
      end
   end

   assign imem_rsp_valid = pend & ~hold;
   assign imem_rsp_data  = paddr ^ K;

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0;
      redirect_valid = 1'b0;
      hold = 1'b0;
      if_ready = 1'b0;
      imem_req_ready = 1'b1;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      step();
      #1;
      checks++;
      if (if_valid !== 1'b0) begin
         fails++; $display("FAIL rst_if_valid got %b want 0", if_valid);
      end
      checks++;
      if (if_pc !== 32'h0 || if_instr !== 32'h0) begin
         fails++; $display("FAIL rst_if_data got %h/%h want 0/0", if_pc, if_instr);
      end
      checks++;
      if (imem_req_valid !== 1'b0) begin
         fails++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid);
      end
      checks++;
      if (next_pc !== 32'h0) begin
         fails++; $display("FAIL rst_next_pc got %h want 0", next_pc);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      checks++;
      if (fetch_misalign !== 1'b0) begin
         fails++; $display("FAIL rst_misalign got %b want 0", fetch_misalign);
      end
`endif
   endtask

   task automatic test_stream;
      logic [31:0] exp_pc;
      logic [31:0] acc_pc;
      int n;
      do_reset();
      if_ready = 1'b1;
      exp_pc = 32'h0;
      acc_pc = 32'h0;
      n = 0;
      for (int c = 0; c < 30 && n < 3; c++) begin
         #1;
         if (imem_req_valid && acc_pc < 32'hC) begin
            checks++;
            if (imem_req_addr !== acc_pc || next_pc !== acc_pc + 32'h4) begin
               fails++;
               $display("FAIL stream_req addr/next %h/%h want %h/%h",
                        imem_req_addr, next_pc, acc_pc, acc_pc + 32'h4);
            end
            acc_pc = acc_pc + 32'h4;
         end
         if (if_valid) begin
            checks++;
            if (if_pc !== exp_pc || if_instr !== (exp_pc ^ K)) begin
               fails++;
               $display("FAIL stream_pop pc/instr %h/%h want %h/%h",
                        if_pc, if_instr, exp_pc, exp_pc ^ K);
            end
            exp_pc = exp_pc + 32'h4;
            n++;
         end
         step();
      end
      checks++;
      if (n != 3) begin
         fails++; $display("FAIL stream_timeout pops %0d want 3", n);
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] exp_pc;
      logic [31:0] acc_pc;
      int n;
      do_reset();
      repeat (8) step();
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin
         fails++; $display("FAIL bp_req_valid got %b want 0", imem_req_valid);
      end
      checks++;
      if (next_pc !== 32'h8) begin
         fails++; $display("FAIL bp_next_pc got %h want 00000008", next_pc);
      end
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
         fails++; $display("FAIL bp_head got %b/%h want 1/0", if_valid, if_pc);
      end
      if_ready = 1'b1;
      exp_pc = 32'h0;
      acc_pc = 32'h8;
      n = 0;
      for (int c = 0; c < 20 && n < 3; c++) begin
         #1;
         if (imem_req_valid && acc_pc == 32'h8) begin
            checks++;
            if (imem_req_addr !== 32'h8 || next_pc !== 32'hC) begin
               fails++;
               $display("FAIL bp_resume addr/next %h/%h want 8/c",
                        imem_req_addr, next_pc);
            end
            acc_pc = 32'hC;
         end
         if (if_valid) begin
            checks++;
            if (if_pc !== exp_pc || if_instr !== (exp_pc ^ K)) begin
               fails++;
               $display("FAIL bp_pop pc/instr %h/%h want %h/%h",
                        if_pc, if_instr, exp_pc, exp_pc ^ K);
            end
            exp_pc = exp_pc + 32'h4;
            n++;
         end
         step();
      end
      checks++;
      if (n != 3 || acc_pc != 32'hC) begin
         fails++; $display("FAIL bp_timeout pops %0d want 3", n);
      end
   endtask

   task automatic test_redirect_wait;
      do_reset();
      step();
      step();
      hold = 1'b1;
      step();
      #1;
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
         fails++; $display("FAIL rw_pre_head got %b/%h want 1/0", if_valid, if_pc);
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      #1;
      checks++;
      if (next_pc !== 32'h100 || imem_req_valid !== 1'b0) begin
         fails++; $display("FAIL rw_redirect next/req %h/%b want 100/0", next_pc, imem_req_valid);
      end
      step();
      redirect_valid = 1'b0;
      hold = 1'b0;
      #1;
      checks++;
      if (if_valid !== 1'b0) begin
         fails++; $display("FAIL rw_flush if_valid got %b want 0", if_valid);
      end
      checks++;
      if (imem_req_valid !== 1'b0 || next_pc !== 32'h100) begin
         fails++; $display("FAIL rw_drain req/next %b/%h want 0/100", imem_req_valid, next_pc);
      end
      step();
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || if_valid !== 1'b0) begin
         fails++;
         $display("FAIL rw_restart req/addr/ifv %b/%h/%b want 1/100/0",
                  imem_req_valid, imem_req_addr, if_valid);
      end
      step();
      step();
      #1;
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== (32'h100 ^ K)) begin
         fails++;
         $display("FAIL rw_first got %b/%h/%h want 1/100/%h",
                  if_valid, if_pc, if_instr, 32'h100 ^ K);
      end
   endtask

   task automatic test_redirect_rsp;
      do_reset();
      if_ready = 1'b1;
      step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      #1;
      checks++;
      if (imem_rsp_valid !== 1'b1 || next_pc !== 32'h200 || imem_req_valid !== 1'b0) begin
         fails++;
         $display("FAIL rr_same rsp/next/req %b/%h/%b want 1/200/0",
                  imem_rsp_valid, next_pc, imem_req_valid);
      end
      step();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (if_valid !== 1'b0) begin
         fails++; $display("FAIL rr_stale if_valid got %b want 0", if_valid);
      end
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
         fails++; $display("FAIL rr_run req/addr %b/%h want 1/200", imem_req_valid, imem_req_addr);
      end
      step();
      step();
      #1;
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
         fails++; $display("FAIL rr_first got %b/%h want 1/200", if_valid, if_pc);
      end
   endtask

   task automatic test_wrap;
      do_reset();
      if_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
         fails++; $display("FAIL wrap_req got %b/%h want 1/fffffffc", imem_req_valid, imem_req_addr);
      end
      checks++;
      if (next_pc !== 32'h0) begin
         fails++; $display("FAIL wrap_next got %h want 00000000", next_pc);
      end
      step();
      step();
      #1;
      checks++;
      if (if_pc !== 32'hFFFF_FFFC || if_instr !== (32'hFFFF_FFFC ^ K)) begin
         fails++; $display("FAIL wrap_pop got %h/%h", if_pc, if_instr);
      end
   endtask

   task automatic test_misalign;
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc = 32'h102;
      step();
      redirect_valid = 1'b0;
      #1;
`ifdef FETCH_MISALIGN_TRAP_EN
      checks++;
      if (imem_req_valid !== 1'b0 || next_pc !== 32'h102) begin
         fails++; $display("FAIL mis_block req/next %b/%h want 0/102", imem_req_valid, next_pc);
      end
      step();
      #1;
      checks++;
      if (fetch_misalign !== 1'b1 || imem_req_valid !== 1'b0 || next_pc !== 32'h102) begin
         fails++;
         $display("FAIL mis_trap flag/req/next %b/%b/%h want 1/0/102",
                  fetch_misalign, imem_req_valid, next_pc);
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'h104;
      step();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (fetch_misalign !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h104) begin
         fails++;
         $display("FAIL mis_clear flag/req/addr %b/%b/%h want 0/1/104",
                  fetch_misalign, imem_req_valid, imem_req_addr);
      end
`else
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
         fails++; $display("FAIL mis_addr req/addr %b/%h want 1/100", imem_req_valid, imem_req_addr);
      end
      checks++;
      if (next_pc !== 32'h106) begin
         fails++; $display("FAIL mis_next got %h want 106", next_pc);
      end
`endif
   endtask

   task automatic test_reset_mid;
      do_reset();
      step();
      reset = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || next_pc !== 32'h0 || if_valid !== 1'b0) begin
         fails++;
         $display("FAIL midrst req/next/ifv %b/%h/%b want 0/0/0",
                  imem_req_valid, next_pc, if_valid);
      end
      step();
      reset = 1'b1;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         fails++; $display("FAIL midrst_run req/addr %b/%h want 1/0", imem_req_valid, imem_req_addr);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_redirect_rsp();
      test_wrap();
      test_misalign();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
